// File: rtl/seq_mult_unit_if.sv
// Handshake and data bundle between the ALU control and the shift-add multiplier.
interface seq_mult_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic               sgn;
    logic               start;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output in1, in2, sgn, start,
        input  busy, done, product
    );

    modport slave (
        input  in1, in2, sgn, start,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult_unit.sv
// Iterative shift-add multiplier, one multiplier bit per clock, signed or unsigned.
// Signed operands are reduced to magnitudes and the sign is reapplied to the final sum.
module seq_mult_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mult_unit_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CntW-1:0]    cnt_q;
    logic               neg_q;

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [2*WIDTH-1:0] acc_next;
    logic               last;

    // Magnitude of the most negative value still fits in WIDTH unsigned bits.
    always_comb begin
        mag1 = bus.in1;
        mag2 = bus.in2;
        if (bus.sgn && bus.in1[WIDTH-1]) mag1 = WIDTH'(0) - bus.in1;
        if (bus.sgn && bus.in2[WIDTH-1]) mag2 = WIDTH'(0) - bus.in2;
        acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        last     = (cnt_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.product <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, mag1};
                        mplier_q <= mag2;
                        neg_q    <= bus.sgn & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        bus.busy <= 1'b1;
                        state_q  <= StCalc;
                    end else begin
                        bus.busy <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                StCalc: begin
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (last) begin
                        bus.product <= neg_q ? ('0 - acc_next) : acc_next;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_unit.sv
// Self-checking bench for seq_mult_unit: directed corners, randomized operands, handshake cases.
module tb_seq_mult_unit;
    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic [63:0] prev_prod;

    seq_mult_unit_if #(.WIDTH(W)) bus ();

    seq_mult_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge, then scramble inputs to prove they are latched.
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.in1   = a;
        bus.in2   = b;
        bus.sgn   = s;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.in1   = $urandom;
        bus.in2   = $urandom;
        bus.sgn   = 1'($urandom_range(0, 1));
    endtask

    // Expect exactly W busy cycles with a stable product; optionally raise start mid-way.
    task automatic calc_phase(input string tag, input int poke);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < int'(W); i++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.product !== prev_prod) ok = 1'b0;
            if (i == poke) begin
                bus.start = 1'b1;
                bus.in1   = 32'd3;
                bus.in2   = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL %s calc_window: busy/done/product not held for %0d cycles", tag, W);
        else n_pass++;
    endtask

    task automatic done_phase(input string tag, input logic [63:0] exp);
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.product !== exp)
            $display("FAIL %s done: done=%b busy=%b product=%h, expected done=1 busy=0 product=%h",
                     tag, bus.done, bus.busy, bus.product, exp);
        else n_pass++;
        prev_prod = exp;
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.product !== prev_prod)
            $display("FAIL %s idle: done=%b busy=%b product=%h, expected 0 0 %h",
                     tag, bus.done, bus.busy, bus.product, prev_prod);
        else n_pass++;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s);
        logic [63:0] exp;
        exp = model(a, b, s);
        accept(a, b, s);
        calc_phase(tag, -1);
        done_phase(tag, exp);
        tick();
        check_idle(tag);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;
        bus.sgn   = 1'b0;
        tick();
        tick();
        prev_prod = '0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'd0)
            $display("FAIL reset: busy=%b done=%b product=%h, expected 0 0 0",
                     bus.busy, bus.done, bus.product);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        run_op("u7x6", 32'd7, 32'd6, 1'b0);
        run_op("s-3x5", 32'hFFFFFFFD, 32'd5, 1'b1);
        run_op("u-3x5", 32'hFFFFFFFD, 32'd5, 1'b0);
        run_op("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("smin2", 32'h80000000, 32'h80000000, 1'b1);
        run_op("sminx1", 32'h80000000, 32'd1, 1'b1);
        n_checks++;
        if (prev_prod !== 64'hFFFFFFFF80000000)
            $display("FAIL model_anchor: model=%h expected=%h", prev_prod, 64'hFFFFFFFF80000000);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] corners [5];
        logic [31:0] a;
        logic [31:0] b;
        corners = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        for (int i = 0; i < 20; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            run_op($sformatf("rand%0d", i), a, b, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_ignore_start();
        accept(32'd10, 32'd10, 1'b0);
        calc_phase("ignore", 4);
        done_phase("ignore", 64'd100);
        tick();
        check_idle("ignore");
    endtask

    task automatic test_back_to_back();
        accept(32'd10, 32'd10, 1'b0);
        calc_phase("b2b_first", -1);
        done_phase("b2b_first", 64'd100);
        accept(32'd3, 32'd3, 1'b0);
        calc_phase("b2b_second", -1);
        done_phase("b2b_second", 64'd9);
        tick();
        check_idle("b2b");
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        accept(32'd1000, 32'd1000, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        rst_n = 1'b0;
        tick();
        prev_prod = '0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'd0)
            $display("FAIL reset_mid: busy=%b done=%b product=%h, expected 0 0 0",
                     bus.busy, bus.done, bus.product);
        else n_pass++;
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
            tick();
        end
        n_checks++;
        if (saw_done) $display("FAIL reset_mid_quiet: activity=1 after aborted op, expected 0");
        else n_pass++;
        run_op("post_reset", 32'd2, 32'd2, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        prev_prod = '0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
